gpr_file_sb: RTL and testbench

Parametrised successor to the pipeline's general-purpose register file. Provides two synchronous read ports, one write port with write-through bypass, an optional hardwired zero register, and a sequenced hardware clear after reset. Adds a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers. Sits between decode (reads, issue) and write-back (writes).

---
 rtl/gpr_file_sb.sv | 125 ++++++++++++
 tb/tb_gpr_file_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_sb.sv
// General-purpose register file: 2 sync read ports, 1 write port with bypass, busy scoreboard.
// Latency: reads and busy flags are registered, 1 cycle; Ready rises DEPTH cycles after reset release.
// Backpressure: none; writes and issues are ignored while the post-reset clear runs (Ready=0).
module gpr_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WData,
    input  logic              RegWrite,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic [DATA_W-1:0] RData1,
    output logic [DATA_W-1:0] RData2,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Ready
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DATA_W-1:0] rdata1_q, rdata2_q;
    logic [DATA_W-1:0] rdata1_d, rdata2_d;
    logic              busy1_q, busy2_q;
    logic              ready_q;
    logic              run;
    logic              wr_en;
    logic              iss_en;

    // Register 0 is immune to writes and issues when it is hardwired to zero.
    assign run    = (state_q == ST_RUN);
    assign wr_en  = run && RegWrite && !(ZERO_REG && (WA == '0));
    assign iss_en = run && Issue && !(ZERO_REG && (IssueAddr == '0));

    // Scoreboard next state: a write retires the producer, a new issue re-marks (issue wins).
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[WA] = 1'b0;
        end
        if (iss_en) begin
            busy_d[IssueAddr] = 1'b1;
        end
    end

    // Read data as seen after this edge's write: bypass first, then zero register, then storage.
    always_comb begin
        rdata1_d = regs_q[RS1];
        rdata2_d = regs_q[RS2];
        if (ZERO_REG && (RS1 == '0)) begin
            rdata1_d = '0;
        end
        if (ZERO_REG && (RS2 == '0)) begin
            rdata2_d = '0;
        end
        if (wr_en && (WA == RS1)) begin
            rdata1_d = WData;
        end
        if (wr_en && (WA == RS2)) begin
            rdata2_d = WData;
        end
    end

    // Storage: the clear sweep owns the array in CLEAR, the write port owns it in RUN.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state_q == ST_CLEAR) begin
                regs_q[idx_q] <= '0;
            end else if (wr_en) begin
                regs_q[WA] <= WData;
            end
        end
    end

    // Control FSM with registered read/busy/ready outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_CLEAR;
            idx_q    <= '0;
            busy_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            busy1_q  <= 1'b0;
            busy2_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    idx_q <= idx_q + ADDR_W'(1);
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q   <= busy_d;
                    rdata1_q <= rdata1_d;
                    rdata2_q <= rdata2_d;
                    busy1_q  <= busy_d[RS1];
                    busy2_q  <= busy_d[RS2];
                end
            endcase
        end
    end

    assign RData1 = rdata1_q;
    assign RData2 = rdata2_q;
    assign Busy1  = busy1_q;
    assign Busy2  = busy2_q;
    assign Ready  = ready_q;
endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] RS1, RS2, WA, IssueAddr;
    logic [DATA_W-1:0] WData;
    logic              RegWrite, Issue;
    logic [DATA_W-1:0] RData1, RData2;
    logic              Busy1, Busy2, Ready;

    int checks = 0;
    int fails  = 0;

    gpr_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .RS1(RS1), .RS2(RS2), .WA(WA), .WData(WData),
        .RegWrite(RegWrite), .Issue(Issue), .IssueAddr(IssueAddr),
        .RData1(RData1), .RData2(RData2), .Busy1(Busy1), .Busy2(Busy2), .Ready(Ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register contents, busy set, cycles since reset.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_busy [DEPTH];
    int                m_cnt   = 0;
    bit                m_valid = 0;
    logic [DATA_W-1:0] m_rd1, m_rd2;
    logic              m_b1, m_b2, m_ready;

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid = 1;
            m_cnt   = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 0;
            end
            m_rd1 = '0; m_rd2 = '0; m_b1 = 0; m_b2 = 0; m_ready = 0;
        end else if (m_valid) begin
            if (m_cnt < DEPTH) begin
                m_cnt++;
                m_rd1 = '0; m_rd2 = '0; m_b1 = 0; m_b2 = 0;
                m_ready = (m_cnt == DEPTH);
            end else begin
                if (RegWrite && WA != 0) m_mem[WA] = WData;
                if (RegWrite) m_busy[WA] = 0;
                if (Issue && IssueAddr != 0) m_busy[IssueAddr] = 1;
                m_rd1   = (RS1 == 0) ? '0 : m_mem[RS1];
                m_rd2   = (RS2 == 0) ? '0 : m_mem[RS2];
                m_b1    = m_busy[RS1];
                m_b2    = m_busy[RS2];
                m_ready = 1;
            end
        end
    end

    // Compare DUT against the model every cycle once the model has seen a reset.
    always @(negedge Clk) begin
        if (m_valid) begin
            chk("rdata1", RData1, m_rd1);
            chk("rdata2", RData2, m_rd2);
            chk("busy1", {31'b0, Busy1}, {31'b0, m_b1});
            chk("busy2", {31'b0, Busy2}, {31'b0, m_b2});
            chk("ready", {31'b0, Ready}, {31'b0, m_ready});
        end
    end

    task automatic idle();
        Reset = 0; RegWrite = 0; Issue = 0;
        WA = '0; WData = '0; IssueAddr = '0; RS1 = '0; RS2 = '0;
    endtask

    // One clock: inputs already driven, advance to the next negedge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1; WA = a; WData = d;
        step();
        RegWrite = 0;
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (!Ready && n < 40) begin
            step();
            n++;
        end
        chk(name, {31'b0, Ready}, 32'd1);
    endtask

    int n;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        @(negedge Clk);

        // Clear sequence with a write attempted during CLEAR.
        Reset = 1;
        step();
        chk("reset_ready", {31'b0, Ready}, 32'd0);
        chk("reset_rdata1", RData1, 32'd0);
        chk("reset_busy1", {31'b0, Busy1}, 32'd0);
        Reset = 0; RegWrite = 1; WA = 5'd3; WData = 32'hDEADBEEF;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("clear_ready", {31'b0, Ready}, (k == DEPTH) ? 32'd1 : 32'd0);
        end
        RegWrite = 0; RS1 = 5'd3;
        step();
        chk("clear_write_ignored", RData1, 32'd0);

        // Write with bypass, then hold.
        RS1 = 5'd5;
        wr(5'd5, 32'h12345678);
        chk("bypass", RData1, 32'h12345678);
        step();
        chk("read_after_write", RData1, 32'h12345678);

        // Zero register.
        wr(5'd0, 32'hFFFFFFFF);
        RS1 = 5'd0; RS2 = 5'd0;
        step();
        chk("zero_rd1", RData1, 32'd0);
        chk("zero_rd2", RData2, 32'd0);
        Issue = 1; IssueAddr = 5'd0;
        step();
        chk("zero_busy", {31'b0, Busy1}, 32'd0);
        Issue = 0;

        // Scoreboard set/clear/set-wins.
        RS2 = 5'd7; Issue = 1; IssueAddr = 5'd7;
        step();
        chk("sb_set", {31'b0, Busy2}, 32'd1);
        Issue = 0;
        wr(5'd7, 32'h7);
        chk("sb_clear", {31'b0, Busy2}, 32'd0);
        Issue = 1; IssueAddr = 5'd7; RegWrite = 1; WA = 5'd7; WData = 32'h77;
        step();
        chk("sb_set_wins", {31'b0, Busy2}, 32'd1);
        idle();

        // Reset from RUN clears data and busy.
        RS1 = 5'd9;
        wr(5'd9, 32'hA5A5A5A5);
        Issue = 1; IssueAddr = 5'd9;
        step();
        Issue = 0;
        chk("r9_data", RData1, 32'hA5A5A5A5);
        chk("r9_busy", {31'b0, Busy1}, 32'd1);
        Reset = 1;
        step();
        Reset = 0;
        wait_ready("rerun_ready", n);
        chk("rerun_latency", n, 32'd32);
        RS1 = 5'd9;
        step();
        chk("r9_cleared", RData1, 32'd0);
        chk("r9_unbusy", {31'b0, Busy1}, 32'd0);

        // Reset reasserted mid-clear restarts the full sweep.
        Reset = 1;
        step();
        Reset = 0;
        for (int k = 0; k < 10; k++) step();
        Reset = 1;
        step();
        Reset = 0;
        wait_ready("midclear_ready", n);
        chk("midclear_latency", n, 32'd32);

        // Dual port same address.
        wr(5'd12, 32'h0000BEEF);
        RS1 = 5'd12; RS2 = 5'd12;
        step();
        chk("dual_rd1", RData1, 32'h0000BEEF);
        chk("dual_rd2", RData2, 32'h0000BEEF);

        // Randomized traffic with narrow address range to provoke hazards and bypasses.
        for (int c = 0; c < 3000; c++) begin
            Reset     = ($urandom_range(0, 299) == 0);
            RegWrite  = $urandom_range(0, 1);
            Issue     = ($urandom_range(0, 2) == 0);
            WA        = 5'($urandom_range(0, 11));
            IssueAddr = 5'($urandom_range(0, 11));
            RS1       = 5'($urandom_range(0, 11));
            RS2       = ($urandom_range(0, 3) == 0) ? RS1 : 5'($urandom_range(0, 11));
            WData     = $urandom;
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
